// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority mask, registered grant and an optional
// hold limit that forces the holder off the resource when others are waiting.
module rr_arbiter #(
  parameter int unsigned  WIDTH          = 8,
  parameter int unsigned  IMPLEMENTATION = 0,
  parameter int unsigned  HOLD_MAX       = 0,
  localparam int unsigned WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  output logic [WIDTH-1:0]     gnt,
  output logic                 gnt_vld,
  output logic [WIDTH_LOG-1:0] gnt_idx
);

  localparam int unsigned CntW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_MAX - 1);

  if (IMPLEMENTATION > 2) begin : g_bad_impl
    $fatal(1, "rr_arbiter: unsupported IMPLEMENTATION %0d", IMPLEMENTATION);
  end
  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "rr_arbiter: WIDTH must be at least 2");
  end

  // Isolate the lowest set bit; the three styles are functionally identical.
  function automatic logic [WIDTH-1:0] lsb_onehot(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] oh;
    logic [WIDTH-1:0] t;
    logic             found;
    oh    = '0;
    t     = c;
    found = 1'b0;
    if (IMPLEMENTATION == 1) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (c[i] && !found) begin
          oh[i] = 1'b1;
          found = 1'b1;
        end
      end
    end else if (IMPLEMENTATION == 2) begin
      // Prefix-OR upward, then keep only the bit with nothing set below it.
      for (int unsigned k = 1; k < WIDTH; k = k * 2) begin
        t = t | (t << k);
      end
      oh = c & ~(t << 1);
    end else begin
      oh = c & (~c + WIDTH'(1));
    end
    return oh;
  endfunction

  function automatic logic [WIDTH_LOG-1:0] oh_to_idx(input logic [WIDTH-1:0] oh);
    logic [WIDTH_LOG-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) idx = idx | WIDTH_LOG'(i);
    end
    return idx;
  endfunction

  logic [WIDTH-1:0] msk_q;
  logic [CntW-1:0]  cnt_q;

  logic             holder_req;
  logic             preempt;
  logic             load;
  logic [WIDTH-1:0] others;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] win;

  always_comb begin
    holder_req = gnt_vld && req[gnt_idx];
    others     = req & ~gnt;
    preempt    = (HOLD_MAX > 0) && holder_req && (cnt_q == CntLast) && (|others);
    load       = !holder_req || preempt;
    cand       = preempt ? others : req;
    masked     = cand & msk_q;
    win        = (|masked) ? lsb_onehot(masked) : lsb_onehot(cand);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
      msk_q   <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      gnt     <= win;
      gnt_vld <= |win;
      gnt_idx <= oh_to_idx(win);
      cnt_q   <= '0;
      // Mask keeps only bits above the winner; an empty result leaves fairness state alone.
      if (|win) msk_q <= ~(win | (win - WIDTH'(1)));
    end else if ((HOLD_MAX > 0) && (cnt_q != CntLast)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one resource between `WIDTH` requesters. It builds on the team's rightmost-priority-to-one-hot conversion: a rotating mask makes the search start just above the last winner, and a registered grant is held while the winner keeps requesting. An optional hold limit forces preemption when others are waiting. The block sits in front of any shared datapath (bus port, memory bank, ALU) and drives that datapath's select from `gnt` / `gnt_idx`.

## Interface
- `WIDTH`, 8: number of requesters, ≥ 2.
- `WIDTH_LOG`, $clog2(WIDTH): localparam, index width.
- `IMPLEMENTATION`, 0: internal priority-to-one-hot style (0 adder, 1 loop, 2 vector). Any other value is a `$fatal` at elaboration.
- `HOLD_MAX`, 0: maximum consecutive grant cycles before forced preemption. 0 disables preemption.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `req`  input  WIDTH  per-requester request, level-sensitive.
- `gnt`  output  WIDTH  registered one-hot grant, or all zero.
- `gnt_vld`  output  1  registered; equals `|gnt`.
- `gnt_idx`  output  WIDTH_LOG  registered binary index of the `gnt` bit; 0 when `gnt_vld`=0.

## Operation
- State: `gnt`, `gnt_idx`, `gnt_vld`, `msk` (WIDTH bits), and hold counter `cnt` ($clog2(HOLD_MAX+1) bits, absent when HOLD_MAX=0).
- Reset values: `gnt`=0, `gnt_vld`=0, `gnt_idx`=0, `msk`=0, `cnt`=0.
- **IDLE** (`gnt_vld`=0)
  - `req`≠0: arbitrate and load the result into `gnt` → GRANT.
  - `req`=0: stay in IDLE.
- **GRANT** (`gnt_vld`=1): holder is `g` = `gnt_idx`.
  - `req[g]`=1 and no preemption: keep `gnt`; `cnt`++ (saturating).
  - `req[g]`=0: re-arbitrate on `req` in the same edge. If the result is nonzero, go directly to the new grant with no idle cycle. If it is zero, go to IDLE.
  - Preemption: HOLD_MAX>0, `cnt`==HOLD_MAX-1, `req[g]`=1, and (`req` & ~`gnt`)≠0. Re-arbitrate on `req` & ~`gnt`. The holder loses the grant even though it is still requesting.
- Arbitration on candidate vector `c`:
  - `m` = `c` & `msk`.
  - If `m`≠0, winner = rightmost one of `m`; otherwise winner = rightmost one of `c`.
  - Both searches use the one-hot conversion with the selected IMPLEMENTATION.
- On every grant load with winner `w`:
  - `msk` = bits strictly above `w` (`msk[i]`=1 iff i>`w`). When `w`=WIDTH-1, `msk`=0.
  - `cnt` = 0; `gnt_idx` = `w`.
- `msk` changes only on grant loads. Release to IDLE leaves `msk` unchanged, so fairness carries across idle periods.
- Invariants: `gnt` always has zero or one bit set. `gnt` is never set for a requester whose `req` was 0 at the loading edge.

## Timing
- Request to grant: `req[i]` sampled high at edge n → `gnt[i]` visible after edge n (1-cycle latency). No combinational path from `req` to any output.
- Release: `req[g]` low at edge m → `gnt` changes after edge m. The holder never sees a grant cycle after its own deassertion was sampled.
- Back-to-back handover: zero bubble cycles between holders when others are pending.
- Preemption:
  - Holder owns the grant for exactly HOLD_MAX cycles, then `gnt` moves to the next waiting requester in round-robin order.
  - With no other requests pending, `cnt` saturates and the holder keeps the grant indefinitely.
- Simultaneous events:
  - Holder drop and new requests at the same edge are resolved in one arbitration.
  - A requester asserting `req` at the same edge the holder drops competes normally.
- Reset mid-operation: `rst` high at any edge forces all reset values after that edge, regardless of `req`. The first grant after reset goes to the lowest-index active requester.
- Wrap-around: after requester WIDTH-1 wins, the search restarts at index 0.

## Test plan
- WIDTH=4, HOLD_MAX=0. Reset, then `req`=4'b1111 constant. Each winner drops `req` for one cycle after holding 2 cycles, then re-raises it. Required grant order: 0,1,2,3,0,…; `gnt_idx` matches `gnt` each cycle; no bubble cycles.
- `req`=4'b0100 at edge 5 → `gnt`=4'b0100, `gnt_idx`=2 after edge 5. `req`=0 at edge 9 → `gnt`=0, `gnt_vld`=0 after edge 9.
- After a grant to index 3, `req`=4'b1001 → grant to index 0 (wrap-around). Next handover → index 3.
- HOLD_MAX=3. Requester 1 holds `req` high and requester 2 requests → `gnt[1]` for exactly 3 cycles, then `gnt`=4'b0100. Requester 1 alone with HOLD_MAX=3 → grant held 10+ cycles.
- While `gnt`=4'b0010, assert `rst` for 1 cycle with `req`=4'b1010 → all outputs 0 after the reset edge. `gnt`=4'b0010 one cycle later, because `msk`=0 selects the lowest index.
- Run all IMPLEMENTATION values 0/1/2 with 10k random `req` cycles against a reference model → identical `gnt` sequences. Assert one-hot-or-zero every cycle; assert no grant to a non-requester.
